// File: rtl/vec_seq.sv
// Vector element sequencer: steps the execute datapath through one vector
// instruction in beats of LANES elements, stalling issue until retirement.
// Optional build macro: VSEQ_PRED_EN adds a per-lane predicate mask that is
// latched at accept and ANDed into every beat's lane enables.
module vec_seq #(
   parameter int unsigned LANES    = 4,
   parameter int unsigned VLEN_W   = 8,
   parameter logic [3:0]  STORE_OP = 4'b0011
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic [3:0]          opcode,
   input  logic [VLEN_W-1:0]   vlen,
   input  logic                flush,
   output logic                elem_valid,
   input  logic                elem_ack,
   output logic [VLEN_W:0]     elem_idx,
   output logic [LANES-1:0]    lane_en,
   output logic [3:0]          op_q,
   output logic                reg_write,
   output logic                mem_write,
   output logic                stall,
   output logic                done
`ifdef VSEQ_PRED_EN
   ,
   input  logic [LANES-1:0]    pred_mask
`endif
);

   localparam int unsigned IDX_W = VLEN_W + 1;
   // One extra bit so index + LANES comparisons can never overflow.
   localparam int unsigned CMP_W = VLEN_W + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          op_d;
   logic [VLEN_W-1:0]   vlen_q, vlen_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                last_beat;
   logic                any_lane;
`ifdef VSEQ_PRED_EN
   logic [LANES-1:0]    pred_q, pred_d;
`endif

   // State-only decodes toward issue and the datapath.
   assign issue_ready = (state_q == S_IDLE);
   assign elem_valid  = (state_q == S_RUN);
   assign stall       = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign elem_idx    = elem_valid ? idx_q : '0;

   // Beat is last once the next beat would start at or past the vector end.
   assign last_beat = (CMP_W'(idx_q) + CMP_W'(LANES)) >= CMP_W'(vlen_q);

   // Per-lane enables: in-range lanes of the current beat, optionally predicated.
   always_comb begin
      lane_en = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         lane_en[i] = elem_valid && ((CMP_W'(idx_q) + CMP_W'(i)) < CMP_W'(vlen_q));
      end
`ifdef VSEQ_PRED_EN
      lane_en = lane_en & pred_q;
`endif
   end

`ifdef VSEQ_PRED_EN
   assign any_lane = |lane_en;
`else
   assign any_lane = 1'b1;
`endif

   // Write strobes fire on an acknowledged beat, steered by the latched opcode.
   assign reg_write = elem_valid && elem_ack && any_lane && (op_q != STORE_OP);
   assign mem_write = elem_valid && elem_ack && any_lane && (op_q == STORE_OP);

   // Next-state and datapath register updates; flush overrides to IDLE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      vlen_d  = vlen_q;
      idx_d   = idx_q;
`ifdef VSEQ_PRED_EN
      pred_d  = pred_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (issue_valid && !flush) begin
               op_d    = opcode;
               vlen_d  = vlen;
               idx_d   = '0;
`ifdef VSEQ_PRED_EN
               pred_d  = pred_mask;
`endif
               state_d = (vlen == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (elem_ack) begin
               idx_d = idx_q + IDX_W'(LANES);
               if (last_beat) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (flush) begin
         state_d = S_IDLE;
      end
   end

   // State and latched instruction registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         vlen_q  <= '0;
         idx_q   <= '0;
`ifdef VSEQ_PRED_EN
         pred_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         vlen_q  <= vlen_d;
         idx_q   <= idx_d;
`ifdef VSEQ_PRED_EN
         pred_q  <= pred_d;
`endif
      end
   end

endmodule

// File: tb/tb_vec_seq.sv
// Directed bench for vec_seq (LANES=4, VLEN_W=8, STORE_OP=4'b0011).
// Build with VSEQ_PRED_EN defined to also exercise the predicate mask.
module tb_vec_seq;

   logic       clk;
   logic       reset;
   logic       issue_valid;
   logic       issue_ready;
   logic [3:0] opcode;
   logic [7:0] vlen;
   logic       flush;
   logic       elem_valid;
   logic       elem_ack;
   logic [8:0] elem_idx;
   logic [3:0] lane_en;
   logic [3:0] op_q;
   logic       reg_write;
   logic       mem_write;
   logic       stall;
   logic       done;
`ifdef VSEQ_PRED_EN
   logic [3:0] pred_mask;
`endif

   int checks = 0;
   int errors = 0;

   logic [18:0] got;
   logic [18:0] exp;

   vec_seq #(.LANES(4), .VLEN_W(8), .STORE_OP(4'b0011)) dut (
      .clk        (clk),
      .reset      (reset),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .opcode     (opcode),
      .vlen       (vlen),
      .flush      (flush),
      .elem_valid (elem_valid),
      .elem_ack   (elem_ack),
      .elem_idx   (elem_idx),
      .lane_en    (lane_en),
      .op_q       (op_q),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .stall      (stall),
      .done       (done)
`ifdef VSEQ_PRED_EN
      ,
      .pred_mask  (pred_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed snapshot: {issue_ready, stall, done, elem_valid, elem_idx[8:0], lane_en[3:0], reg_write, mem_write}
   function automatic logic [18:0] snap();
      return {issue_ready, stall, done, elem_valid, elem_idx, lane_en, reg_write, mem_write};
   endfunction

   localparam logic [18:0] IDLE_V = {1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 4'b0000, 1'b0, 1'b0};
   localparam logic [18:0] DONE_V = {1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 4'b0000, 1'b0, 1'b0};

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      got = snap();
      checks++;
      if (got !== IDLE_V) begin
         errors++;
         $display("FAIL reset_outputs got %b exp %b", got, IDLE_V);
      end
      checks++;
      if (op_q !== 4'd0) begin
         errors++;
         $display("FAIL reset_op_q got %h exp %h", op_q, 4'd0);
      end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_basic();
      issue_valid = 1'b1; opcode = 4'b0001; vlen = 8'd8; elem_ack = 1'b1;
      #2;
      checks++;
      if (issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready0 got %b exp 1", issue_ready);
      end
      step(); issue_valid = 1'b0; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_beat0 got %b exp %b", got, exp); end
      checks++;
      if (op_q !== 4'b0001) begin errors++; $display("FAIL basic_op_q got %h exp 1", op_q); end
      step(); #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_beat1 got %b exp %b", got, exp); end
      step(); #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL basic_done got %b exp %b", got, DONE_V); end
      step(); #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL basic_ready got %b exp %b", got, IDLE_V); end
   endtask

   task automatic test_store();
      issue_valid = 1'b1; opcode = 4'b0011; vlen = 8'd6; elem_ack = 1'b1;
      step(); issue_valid = 1'b0; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b1111, 1'b0, 1'b1};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL store_beat0 got %b exp %b", got, exp); end
      step(); #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b0011, 1'b0, 1'b1};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL store_beat1 got %b exp %b", got, exp); end
      step(); #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL store_done got %b exp %b", got, DONE_V); end
      step(); #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL store_idle got %b exp %b", got, IDLE_V); end
   endtask

   task automatic test_wait();
      issue_valid = 1'b1; opcode = 4'b0010; vlen = 8'd5; elem_ack = 1'b0;
      step(); issue_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b1111, 1'b0, 1'b0};
         got = snap(); checks++;
         if (got !== exp) begin errors++; $display("FAIL wait_hold%0d got %b exp %b", k, got, exp); end
         step();
      end
      elem_ack = 1'b1; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wait_beat0 got %b exp %b", got, exp); end
      step(); #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b0001, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wait_beat1 got %b exp %b", got, exp); end
      step(); #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL wait_done got %b exp %b", got, DONE_V); end
      step(); #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL wait_idle got %b exp %b", got, IDLE_V); end
   endtask

   task automatic test_zero_len();
      issue_valid = 1'b1; opcode = 4'b0001; vlen = 8'd0; elem_ack = 1'b1;
      step(); issue_valid = 1'b0; #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL zero_done got %b exp %b", got, DONE_V); end
      step(); #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL zero_idle got %b exp %b", got, IDLE_V); end
   endtask

   task automatic test_flush();
      issue_valid = 1'b1; opcode = 4'b0100; vlen = 8'd16; elem_ack = 1'b1;
      step(); issue_valid = 1'b0;
      step(); flush = 1'b1; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL flush_beat1 got %b exp %b", got, exp); end
      step(); flush = 1'b0; #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL flush_idle got %b exp %b", got, IDLE_V); end
      // Issue coinciding with flush must be dropped.
      issue_valid = 1'b1; flush = 1'b1; opcode = 4'b0101; vlen = 8'd4;
      step(); issue_valid = 1'b0; flush = 1'b0; #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL flush_issue_drop got %b exp %b", got, IDLE_V); end
      checks++;
      if (op_q !== 4'b0100) begin errors++; $display("FAIL flush_issue_op got %h exp 4", op_q); end
      issue_valid = 1'b1; opcode = 4'b0110; vlen = 8'd4;
      step(); issue_valid = 1'b0; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL flush_reissue got %b exp %b", got, exp); end
      step(); #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL flush_reissue_done got %b exp %b", got, DONE_V); end
      step();
   endtask

   task automatic test_reset_mid_run();
      issue_valid = 1'b1; opcode = 4'b0111; vlen = 8'd16; elem_ack = 1'b1;
      step(); issue_valid = 1'b0;
      step(); #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b1111, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_run got %b exp %b", got, exp); end
      reset = 1'b0; #1;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL rst_async got %b exp %b", got, IDLE_V); end
      checks++;
      if (op_q !== 4'd0) begin errors++; $display("FAIL rst_op_q got %h exp 0", op_q); end
      step(); reset = 1'b1;
      step(); #2;
      got = snap(); checks++;
      if (got !== IDLE_V) begin errors++; $display("FAIL rst_release got %b exp %b", got, IDLE_V); end
   endtask

`ifdef VSEQ_PRED_EN
   task automatic test_pred();
      issue_valid = 1'b1; opcode = 4'b0001; vlen = 8'd8; elem_ack = 1'b1; pred_mask = 4'b0101;
      step(); issue_valid = 1'b0; pred_mask = 4'b1111; #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 4'b0101, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL pred_beat0 got %b exp %b", got, exp); end
      step(); #2;
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 9'd4, 4'b0101, 1'b1, 1'b0};
      got = snap(); checks++;
      if (got !== exp) begin errors++; $display("FAIL pred_beat1 got %b exp %b", got, exp); end
      step(); #2;
      got = snap(); checks++;
      if (got !== DONE_V) begin errors++; $display("FAIL pred_done got %b exp %b", got, DONE_V); end
      step();
   endtask
`endif

   initial begin
      reset = 1'b0; issue_valid = 1'b0; opcode = 4'd0; vlen = 8'd0;
      flush = 1'b0; elem_ack = 1'b0;
`ifdef VSEQ_PRED_EN
      pred_mask = 4'b1111;
`endif
      test_reset();
      test_basic();
      test_store();
      test_wait();
      test_zero_len();
      test_flush();
      test_reset_mid_run();
`ifdef VSEQ_PRED_EN
      test_pred();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
